axi_master_wr: RTL

AXI_MASTER_WR -- requirements
Module: axi_master_wr

---
 rtl/axi_pkg.sv | 17 +
 rtl/axi_master_wr.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the read and write masters: FSM state type and
// fixed AW/AR attribute encodings.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } axi_state_e;

    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] CACHE_BUF  = 4'b0010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_master_wr.sv
// Single-burst AXI4 write master: one AW, len+1 W beats of 64 bits, one B.
// Optional B response checking is enabled by defining AXI_WR_RESP_CHK_EN.
module axi_master_wr
    import axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        wr_start,
    input  logic [29:0] wr_addr,
    input  logic [7:0]  wr_len,
    input  logic [63:0] wr_data,
    output logic        wr_ready,
    output logic        wr_done,
    output logic        wr_err,
    output logic        m_axi_w_handshake,

    output logic [3:0]  m_axi_awid,
    output logic [29:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awlock,
    output logic [3:0]  m_axi_awcache,
    output logic [2:0]  m_axi_awprot,
    output logic [3:0]  m_axi_awqos,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,

    output logic [63:0] m_axi_wdata,
    output logic [7:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,

    input  logic [3:0]  m_axi_bid,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    axi_state_e  state_q;
    logic [29:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  beat_cnt_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        done_q;

    logic        w_hs;
    logic        b_hs;
    logic        wlast;

    assign w_hs  = wvalid_q & m_axi_wready;
    assign b_hs  = bready_q & m_axi_bvalid;
    // Counter stops at len_q on the last beat, so len=255 never needs to wrap.
    assign wlast = wvalid_q & (beat_cnt_q == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_start) begin
                        addr_q    <= wr_addr;
                        len_q     <= wr_len;
                        awvalid_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_awready) begin
                        awvalid_q  <= 1'b0;
                        wvalid_q   <= 1'b1;
                        beat_cnt_q <= '0;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        if (wlast) begin
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= RESP;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AXI_WR_RESP_CHK_EN
    logic err_q;

    // Sticky until the next accepted start so the user can read it after wr_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && wr_start) begin
            err_q <= 1'b0;
        end else if (b_hs && (m_axi_bresp != RESP_OKAY || m_axi_bid != AXI_ID)) begin
            err_q <= 1'b1;
        end
    end

    assign wr_err = err_q;
`else
    logic unused_b;
    assign unused_b = ^{m_axi_bid, m_axi_bresp, b_hs};
    assign wr_err   = 1'b0;
`endif

    assign wr_ready          = (state_q == IDLE);
    assign wr_done           = done_q;
    assign m_axi_w_handshake = w_hs;

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = SIZE_8B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = CACHE_BUF;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = awvalid_q;

    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = 8'hFF;
    assign m_axi_wlast  = wlast;
    assign m_axi_wvalid = wvalid_q;

    assign m_axi_bready = bready_q;

endmodule
